// File: rtl/dallanma_ongorucu_if.sv
`default_nettype none
// ============================================================================
//  Module      : dallanma_ongorucu_if
//  Description : Fetch-side bundle between the execute stage (redirect g1,
//                branch feedback g2) and the PC generator / branch predictor.
//                The slave modport is the predictor, the master modport is
//                whoever drives redirects and consumes the fetch PS.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dallanma_ongorucu_if #(
    parameter int PS_BIT = 32
);
    // fetch-side control
    logic              duraklat_i;
    // g1: redirect
    logic [PS_BIT-1:0] g1_ps_i;
    logic              g1_ps_gecerli_i;
    // g2: branch resolution feedback
    logic [PS_BIT-1:0] g2_ps_i;
    logic              g2_guncelle_i;
    logic              g2_atladi_i;
    logic              g2_hatali_tahmin_i;
    // fetch outputs
    logic [PS_BIT-1:0] ps_o;
    logic              ps_gecerli_o;
    logic              tahmin_atladi_o;
    logic              bosalt_o;

    modport master (
        output duraklat_i,
        output g1_ps_i, g1_ps_gecerli_i,
        output g2_ps_i, g2_guncelle_i, g2_atladi_i, g2_hatali_tahmin_i,
        input  ps_o, ps_gecerli_o, tahmin_atladi_o, bosalt_o
    );

    modport slave (
        input  duraklat_i,
        input  g1_ps_i, g1_ps_gecerli_i,
        input  g2_ps_i, g2_guncelle_i, g2_atladi_i, g2_hatali_tahmin_i,
        output ps_o, ps_gecerli_o, tahmin_atladi_o, bosalt_o
    );
endinterface
`default_nettype wire

// File: rtl/dallanma_ongorucu.sv
`default_nettype none
// ============================================================================
//  Module      : dallanma_ongorucu
//  Description : Fetch PC generator with a direct-mapped BTB and a bimodal
//                2-bit counter per entry. Predicts on the current PS, follows
//                execute-stage redirects, and trains on branch feedback.
//  Revision    : 1.0 - initial release
// ============================================================================
module dallanma_ongorucu #(
    parameter int                 PS_BIT    = 32,
    parameter int                 BTB_SATIR = 32,
    parameter logic [PS_BIT-1:0]  RESET_PS  = 32'h4000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dallanma_ongorucu_if.slave    bus
);

    localparam int IDX_BIT = $clog2(BTB_SATIR);
    localparam int TAG_BIT = PS_BIT - IDX_BIT - 2;

    localparam logic [1:0]        C_SAYAC_RESET = 2'b01;
    localparam logic [1:0]        C_SAYAC_ALLOC = 2'b10;
    localparam logic [PS_BIT-1:0] C_ADIM        = PS_BIT'(4);

    // Fetch PS state
    logic [PS_BIT-1:0]  r_ps;
    logic               r_ps_gecerli;

    // BTB / counter table, one flop set per entry
    logic [BTB_SATIR-1:0] r_gecerli;
    logic [TAG_BIT-1:0]   r_tag   [BTB_SATIR];
    logic [PS_BIT-1:0]    r_hedef [BTB_SATIR];
    logic [1:0]           r_sayac [BTB_SATIR];

    // Read (prediction) side
    logic [IDX_BIT-1:0] w_rd_idx;
    logic [TAG_BIT-1:0] w_rd_tag;
    logic               w_rd_isabet;
    logic               w_tahmin;
    logic [PS_BIT-1:0]  w_sonraki;

    // Write (training) side
    logic [IDX_BIT-1:0] w_wr_idx;
    logic [TAG_BIT-1:0] w_wr_tag;
    logic               w_wr_isabet;
    logic               w_hedef_yaz;

    // Saturating counter helpers
    function automatic logic [1:0] sayac_arttir(input logic [1:0] s);
        return (s == 2'b11) ? s : s + 2'd1;
    endfunction

    function automatic logic [1:0] sayac_azalt(input logic [1:0] s);
        return (s == 2'b00) ? s : s - 2'd1;
    endfunction

    assign w_rd_idx    = r_ps[IDX_BIT+1:2];
    assign w_rd_tag    = r_ps[PS_BIT-1:IDX_BIT+2];
    assign w_rd_isabet = r_gecerli[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign w_tahmin    = w_rd_isabet && r_sayac[w_rd_idx][1];
    // Adder wraps naturally at 2^PS_BIT
    assign w_sonraki   = w_tahmin ? r_hedef[w_rd_idx] : r_ps + C_ADIM;

    assign w_wr_idx    = bus.g2_ps_i[IDX_BIT+1:2];
    assign w_wr_tag    = bus.g2_ps_i[PS_BIT-1:IDX_BIT+2];
    assign w_wr_isabet = r_gecerli[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
    // The corrected target only travels on g1, so a taken mispredict is the
    // one case where a target gets written.
    assign w_hedef_yaz = bus.g2_hatali_tahmin_i && bus.g2_atladi_i;

    assign bus.ps_o            = r_ps;
    assign bus.ps_gecerli_o    = r_ps_gecerli;
    assign bus.tahmin_atladi_o = w_tahmin;
    assign bus.bosalt_o        = bus.g1_ps_gecerli_i && !rst_i;

    // PS register: reset, then redirect, then stall, then predicted next PS
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ps         <= RESET_PS;
            r_ps_gecerli <= 1'b0;
        end else begin
            r_ps_gecerli <= 1'b1;
            if (bus.g1_ps_gecerli_i) begin
                r_ps <= bus.g1_ps_i;
            end else if (!bus.duraklat_i) begin
                r_ps <= w_sonraki;
            end
        end
    end

    // Table training: hits move the counter, taken mispredicts fix or allocate
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_SATIR; i++) begin
                r_gecerli[i] <= 1'b0;
                r_sayac[i]   <= C_SAYAC_RESET;
            end
        end else if (bus.g2_guncelle_i) begin
            if (w_wr_isabet) begin
                if (bus.g2_atladi_i) begin
                    r_sayac[w_wr_idx] <= sayac_arttir(r_sayac[w_wr_idx]);
                end else begin
                    r_sayac[w_wr_idx] <= sayac_azalt(r_sayac[w_wr_idx]);
                end
                if (w_hedef_yaz) begin
                    r_hedef[w_wr_idx] <= bus.g1_ps_i;
                end
            end else if (w_hedef_yaz) begin
                r_gecerli[w_wr_idx] <= 1'b1;
                r_tag[w_wr_idx]     <= w_wr_tag;
                r_hedef[w_wr_idx]   <= bus.g1_ps_i;
                r_sayac[w_wr_idx]   <= C_SAYAC_ALLOC;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dallanma_ongorucu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dallanma_ongorucu
//  Description : Self-checking bench for dallanma_ongorucu: directed vector
//                table, hand-written multi-cycle sequences and randomized
//                traffic against a behavioural predictor model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dallanma_ongorucu;

    localparam int          PS_BIT   = 32;
    localparam int          N_SATIR  = 32;
    localparam logic [31:0] RESET_PS = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dallanma_ongorucu_if #(.PS_BIT(PS_BIT)) bus ();

    dallanma_ongorucu #(
        .PS_BIT    (PS_BIT),
        .BTB_SATIR (N_SATIR),
        .RESET_PS  (RESET_PS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        g1v;
        logic [31:0] g1ps;
        logic        g2u;
        logic [31:0] g2ps;
        logic        atl;
        logic        hat;
        logic        chk;
        logic [31:0] eps;
        logic        ev;
        logic        ep;
        logic        eb;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: table indexed by word address mod entries,
    // tag is the word address divided by the entry count.
    logic [31:0] m_ps;
    logic        m_v;
    bit          m_valid [N_SATIR];
    int unsigned m_tag   [N_SATIR];
    logic [31:0] m_tgt   [N_SATIR];
    int          m_cnt   [N_SATIR];

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % N_SATIR;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / 4) / N_SATIR;
    endfunction

    function automatic bit m_pred();
        int unsigned ix;
        ix = idx_of(m_ps);
        return m_valid[ix] && (m_tag[ix] == tag_of(m_ps)) && (m_cnt[ix] >= 2);
    endfunction

    task automatic model_reset();
        m_ps = RESET_PS;
        m_v  = 1'b0;
        for (int i = 0; i < N_SATIR; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
        end
    endtask

    task automatic model_step(input vec_t v);
        logic [31:0] nxt;
        int unsigned ix;
        bit          hit;
        if (v.rst) begin
            model_reset();
            return;
        end
        nxt = m_pred() ? m_tgt[idx_of(m_ps)] : m_ps + 32'd4;
        if (v.g2u) begin
            ix  = idx_of(v.g2ps);
            hit = m_valid[ix] && (m_tag[ix] == tag_of(v.g2ps));
            if (hit) begin
                if (v.atl) m_cnt[ix] = (m_cnt[ix] < 3) ? m_cnt[ix] + 1 : 3;
                else       m_cnt[ix] = (m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0;
                if (v.hat && v.atl) m_tgt[ix] = v.g1ps;
            end else if (v.hat && v.atl) begin
                m_valid[ix] = 1'b1;
                m_tag[ix]   = tag_of(v.g2ps);
                m_tgt[ix]   = v.g1ps;
                m_cnt[ix]   = 2;
            end
        end
        m_v = 1'b1;
        if (v.g1v)         m_ps = v.g1ps;
        else if (!v.stall) m_ps = nxt;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic rst_v, input logic stall, input logic g1v, input logic [31:0] g1ps,
        input logic g2u, input logic [31:0] g2ps, input logic atl, input logic hat,
        input logic chk, input logic [31:0] eps, input logic ev, input logic ep, input logic eb);
        vec_t v;
        v.rst = rst_v; v.stall = stall; v.g1v = g1v; v.g1ps = g1ps;
        v.g2u = g2u; v.g2ps = g2ps; v.atl = atl; v.hat = hat;
        v.chk = chk; v.eps = eps; v.ev = ev; v.ep = ep; v.eb = eb;
        return v;
    endfunction

    // One clock: drive, check outputs before the edge, advance the model
    task automatic step(input vec_t v, input string name);
        rst                    = v.rst;
        bus.duraklat_i         = v.stall;
        bus.g1_ps_gecerli_i    = v.g1v;
        bus.g1_ps_i            = v.g1ps;
        bus.g2_guncelle_i      = v.g2u;
        bus.g2_ps_i            = v.g2ps;
        bus.g2_atladi_i        = v.atl;
        bus.g2_hatali_tahmin_i = v.hat;
        #1;
        check({name, ".m_ps"},   bus.ps_o,                   m_ps);
        check({name, ".m_vld"},  32'(bus.ps_gecerli_o),      32'(m_v));
        check({name, ".m_pred"}, 32'(bus.tahmin_atladi_o),   32'(m_pred()));
        check({name, ".m_bos"},  32'(bus.bosalt_o),          32'(v.g1v && !v.rst));
        if (v.chk) begin
            check({name, ".ps"},   bus.ps_o,                 v.eps);
            check({name, ".vld"},  32'(bus.ps_gecerli_o),    32'(v.ev));
            check({name, ".pred"}, 32'(bus.tahmin_atladi_o), 32'(v.ep));
            check({name, ".bos"},  32'(bus.bosalt_o),        32'(v.eb));
        end
        @(posedge clk);
        #1;
        model_step(v);
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return RESET_PS + 32'($urandom_range(0, 127)) * 32'd4;
    endfunction

    vec_t tbl [14];
    localparam logic [31:0] A10  = 32'h4000_0010;
    localparam logic [31:0] A100 = 32'h4000_0100;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        // reset/free-run, stall, allocate and predicted-taken sequence
        tbl[0]  = mk(1,0,0,0,   0,0,0,0, 1, 32'h4000_0000,0,0,0);
        tbl[1]  = mk(0,0,0,0,   0,0,0,0, 1, 32'h4000_0000,0,0,0);
        tbl[2]  = mk(0,0,0,0,   0,0,0,0, 1, 32'h4000_0004,1,0,0);
        tbl[3]  = mk(0,1,0,0,   0,0,0,0, 1, 32'h4000_0008,1,0,0);
        tbl[4]  = mk(0,1,0,0,   0,0,0,0, 1, 32'h4000_0008,1,0,0);
        tbl[5]  = mk(0,1,0,0,   0,0,0,0, 1, 32'h4000_0008,1,0,0);
        tbl[6]  = mk(0,0,0,0,   0,0,0,0, 1, 32'h4000_0008,1,0,0);
        tbl[7]  = mk(0,0,0,0,   0,0,0,0, 1, 32'h4000_000C,1,0,0);
        tbl[8]  = mk(0,0,0,0,   0,0,0,0, 1, A10,          1,0,0);
        tbl[9]  = mk(0,0,1,A100,1,A10,1,1, 1, 32'h4000_0014,1,0,1);
        tbl[10] = mk(0,0,0,0,   0,0,0,0, 1, A100,         1,0,0);
        tbl[11] = mk(0,0,1,A10, 0,0,0,0, 1, 32'h4000_0104,1,0,1);
        tbl[12] = mk(0,0,0,0,   0,0,0,0, 1, A10,          1,1,0);
        tbl[13] = mk(0,0,0,0,   0,0,0,0, 1, A100,         1,0,0);

        bus.duraklat_i = 0; bus.g1_ps_gecerli_i = 0; bus.g1_ps_i = 0;
        bus.g2_guncelle_i = 0; bus.g2_ps_i = 0; bus.g2_atladi_i = 0;
        bus.g2_hatali_tahmin_i = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // counter walk on the allocated entry while the PS is held on it
        step(mk(0,0,1,A10,0,0,0,0, 1, 32'h4000_0104,1,0,1), "cnt_redir");
        step(mk(0,1,0,0,1,A10,0,0, 1, A10,1,1,0), "cnt_nt1");
        step(mk(0,1,0,0,1,A10,0,0, 1, A10,1,0,0), "cnt_nt2");
        step(mk(0,1,0,0,1,A10,0,0, 1, A10,1,0,0), "cnt_nt3");
        step(mk(0,1,0,0,1,A10,1,0, 1, A10,1,0,0), "cnt_t1");
        step(mk(0,1,0,0,1,A10,1,0, 1, A10,1,0,0), "cnt_t2");
        step(mk(0,1,0,0,0,0,0,0,   1, A10,1,1,0), "cnt_on");
        step(mk(0,0,0,0,0,0,0,0,   1, A10,1,1,0), "cnt_take");
        step(mk(0,0,0,0,0,0,0,0,   1, A100,1,0,0), "cnt_tgt");

        // redirect beats stall, and PS wraps at the top of the address space
        step(mk(0,1,1,32'h4000_0200,0,0,0,0, 1, 32'h4000_0104,1,0,1), "rd_stall");
        step(mk(0,0,0,0,0,0,0,0, 1, 32'h4000_0200,1,0,0), "rd_land");
        step(mk(0,0,1,32'hFFFF_FFFC,0,0,0,0, 1, 32'h4000_0204,1,0,1), "wrap_rd");
        step(mk(0,0,0,0,0,0,0,0, 1, 32'hFFFF_FFFC,1,0,0), "wrap_top");
        step(mk(0,0,0,0,0,0,0,0, 1, 32'h0000_0000,1,0,0), "wrap_zero");

        // alias: same index as the live entry, different tag
        step(mk(0,0,1,32'h4000_0090,0,0,0,0, 1, 32'h0000_0004,1,0,1), "alias_rd");
        step(mk(0,0,0,0,0,0,0,0, 1, 32'h4000_0090,1,0,0), "alias_miss");
        step(mk(0,0,0,0,0,0,0,0, 1, 32'h4000_0094,1,0,0), "alias_next");

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rv = '0;
            rv.rst   = ($urandom_range(0, 59) == 0);
            rv.stall = ($urandom_range(0, 3) == 0);
            rv.g1v   = ($urandom_range(0, 5) == 0);
            rv.g1ps  = rand_pc();
            rv.g2u   = ($urandom_range(0, 2) == 0);
            rv.g2ps  = rand_pc();
            rv.atl   = $urandom_range(0, 1);
            rv.hat   = rv.g1v && ($urandom_range(0, 1) == 1);
            if (rv.g2u && $urandom_range(0, 1) == 1) rv.g2ps = m_ps;
            step(rv, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
